// File: rtl/output_port_if.sv
// Bundle of the arbitration, downstream-channel and flit signals of one BiNoC output port.
`timescale 1ns/1ps
interface output_port_if #(
    parameter int NUM_IN = 10,
    parameter int FLIT_W = 32
);
    logic              reqDnStr;
    logic              gntDnStr;
    logic              full1;
    logic              full2;
    logic [FLIT_W-1:0] PacketInPort0;
    logic [FLIT_W-1:0] PacketInPort1;
    logic [FLIT_W-1:0] PacketInPort2;
    logic [FLIT_W-1:0] PacketInPort3;
    logic [FLIT_W-1:0] PacketInPort4;
    logic [FLIT_W-1:0] PacketInPort5;
    logic [FLIT_W-1:0] PacketInPort6;
    logic [FLIT_W-1:0] PacketInPort7;
    logic [FLIT_W-1:0] PacketInPort8;
    logic [FLIT_W-1:0] PacketInPort9;
    logic [NUM_IN-1:0] reqInCntr;
    logic [NUM_IN-1:0] gntInCntr;
    logic [FLIT_W-1:0] PacketOut;

    modport master (
        output reqDnStr, gntInCntr, PacketOut,
        input  gntDnStr, full1, full2, reqInCntr,
        input  PacketInPort0, PacketInPort1, PacketInPort2, PacketInPort3, PacketInPort4,
        input  PacketInPort5, PacketInPort6, PacketInPort7, PacketInPort8, PacketInPort9
    );

    modport slave (
        input  reqDnStr, gntInCntr, PacketOut,
        output gntDnStr, full1, full2, reqInCntr,
        output PacketInPort0, PacketInPort1, PacketInPort2, PacketInPort3, PacketInPort4,
        output PacketInPort5, PacketInPort6, PacketInPort7, PacketInPort8, PacketInPort9
    );
endinterface

// File: rtl/output_port.sv
// BiNoC output-port controller: round-robin arbitration over 10 inputs, downstream channel
// request, and flit forwarding with per-VC backpressure; the lock is held until the tail flit.
`timescale 1ns/1ps
module output_port #(
    parameter int NUM_IN = 10,
    parameter int FLIT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    output_port_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    state_t            state;
    logic [3:0]        rr_ptr;
    logic [3:0]        idx;
    logic              vc;
    logic              req_dn;
    logic [FLIT_W-1:0] flit_p1;

    logic [FLIT_W-1:0] flits [NUM_IN];
    logic [FLIT_W-1:0] flit_sel;
    logic [4:0]        pick;
    logic              full_sel;
    logic              accept;
    logic [NUM_IN-1:0] gnt;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == 4'(NUM_IN - 1)) ? 4'd0 : v + 4'd1;
    endfunction

    // Returns {found, index}: first requester at or after ptr, wrapping past the last input.
    function automatic logic [4:0] rr_pick(input logic [NUM_IN-1:0] req, input logic [3:0] ptr);
        logic [3:0] j;
        logic [4:0] r;
        r = '0;
        j = ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!r[4] && req[j]) r = {1'b1, j};
            j = wrap_inc(j);
        end
        return r;
    endfunction

    always_comb begin
        flits[0] = bus.PacketInPort0;
        flits[1] = bus.PacketInPort1;
        flits[2] = bus.PacketInPort2;
        flits[3] = bus.PacketInPort3;
        flits[4] = bus.PacketInPort4;
        flits[5] = bus.PacketInPort5;
        flits[6] = bus.PacketInPort6;
        flits[7] = bus.PacketInPort7;
        flits[8] = bus.PacketInPort8;
        flits[9] = bus.PacketInPort9;
    end

    assign pick     = rr_pick(bus.reqInCntr, rr_ptr);
    assign flit_sel = flits[idx];
    assign full_sel = vc ? bus.full2 : bus.full1;
    assign accept   = (state == XFER) && bus.gntDnStr && !full_sel && (flit_sel[29:28] != TYPE_NONE);

    always_comb begin
        gnt = '0;
        if (accept) gnt[idx] = 1'b1;
    end

    assign bus.gntInCntr = gnt;
    assign bus.reqDnStr  = req_dn;
    assign bus.PacketOut = flit_p1;

    // Stage p0 -> p1: arbitration state and the forwarded flit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 4'd0;
            idx     <= 4'd0;
            vc      <= 1'b0;
            req_dn  <= 1'b0;
            flit_p1 <= '0;
        end else begin
            flit_p1 <= accept ? flit_sel : '0;
            case (state)
                IDLE: begin
                    if (pick[4]) begin
                        idx    <= pick[3:0];
                        vc     <= flits[pick[3:0]][24];
                        req_dn <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.gntDnStr) state <= XFER;
                end
                XFER: begin
                    if (accept && flit_sel[29:28] == TYPE_TAIL) begin
                        rr_ptr <= wrap_inc(idx);
                        req_dn <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: reset, single packet, round-robin, backpressure,
// channel-grant wait and asynchronous reset in mid-packet.
`timescale 1ns/1ps
module tb_output_port;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    output_port_if #(.NUM_IN(10), .FLIT_W(32)) bus ();

    output_port #(.NUM_IN(10), .FLIT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_port(input int i, input logic [31:0] f);
        case (i)
            0: bus.PacketInPort0 = f;
            1: bus.PacketInPort1 = f;
            2: bus.PacketInPort2 = f;
            3: bus.PacketInPort3 = f;
            4: bus.PacketInPort4 = f;
            5: bus.PacketInPort5 = f;
            6: bus.PacketInPort6 = f;
            7: bus.PacketInPort7 = f;
            8: bus.PacketInPort8 = f;
            default: bus.PacketInPort9 = f;
        endcase
    endtask

    // Called at a negedge: offers f on input i, waits (bounded) for the accept strobe,
    // captures the strobe and the flit seen on PacketOut one edge later.
    task automatic serve_flit(input int i, input logic [31:0] f,
                              output logic [9:0] g, output logic [31:0] o, output int waited);
        set_port(i, f);
        waited = 0;
        #1;
        while (bus.gntInCntr == 10'd0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        g = bus.gntInCntr;
        @(posedge clk);
        #1;
        o = bus.PacketOut;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.PacketOut !== 32'h0) begin fails++; $display("FAIL reset_out: got %h need %h", bus.PacketOut, 32'h0); end
        checks++; if (bus.reqDnStr !== 1'b0) begin fails++; $display("FAIL reset_req: got %b need 0", bus.reqDnStr); end
        checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL reset_gnt: got %h need 000", bus.gntInCntr); end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.reqInCntr = 10'b1;
        bus.gntDnStr  = 1'b1;
        set_port(0, 32'h2112_2222);
        #1;
        checks++; if (bus.reqDnStr !== 1'b0) begin fails++; $display("FAIL single_idle_req: got %b need 0", bus.reqDnStr); end
        @(negedge clk); #1;
        checks++; if (bus.reqDnStr !== 1'b1) begin fails++; $display("FAIL single_req: got %b need 1", bus.reqDnStr); end
        checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL single_req_gnt: got %h need 000", bus.gntInCntr); end
        @(negedge clk); #1;
        checks++; if (bus.gntInCntr !== 10'h001) begin fails++; $display("FAIL single_head_gnt: got %h need 001", bus.gntInCntr); end
        @(posedge clk); #1;
        checks++; if (bus.PacketOut !== 32'h2112_2222) begin fails++; $display("FAIL single_head_out: got %h need 21122222", bus.PacketOut); end
        @(negedge clk);
        set_port(0, 32'h1112_3333);
        #1;
        checks++; if (bus.gntInCntr !== 10'h001) begin fails++; $display("FAIL single_body_gnt: got %h need 001", bus.gntInCntr); end
        @(posedge clk); #1;
        checks++; if (bus.PacketOut !== 32'h1112_3333) begin fails++; $display("FAIL single_body_out: got %h need 11123333", bus.PacketOut); end
        @(negedge clk);
        set_port(0, 32'h3112_4444);
        #1;
        checks++; if (bus.gntInCntr !== 10'h001) begin fails++; $display("FAIL single_tail_gnt: got %h need 001", bus.gntInCntr); end
        @(posedge clk); #1;
        checks++; if (bus.PacketOut !== 32'h3112_4444) begin fails++; $display("FAIL single_tail_out: got %h need 31124444", bus.PacketOut); end
        checks++; if (bus.reqDnStr !== 1'b0) begin fails++; $display("FAIL single_req_fall: got %b need 0", bus.reqDnStr); end
        @(negedge clk);
        bus.reqInCntr = 10'h0;
        set_port(0, 32'h0);
    endtask

    task automatic test_round_robin();
        logic [9:0]  g;
        logic [31:0] o;
        int          w;
        // Pointer sits at 1 after the single packet: input 1 beats input 0.
        @(negedge clk);
        bus.reqInCntr = 10'b00_0000_0011;
        set_port(0, 32'h2000_0A00);
        serve_flit(1, 32'h2000_0101, g, o, w);
        checks++; if (g !== 10'h002) begin fails++; $display("FAIL rr_ptr1_gnt: got %h need 002", g); end
        serve_flit(1, 32'h3000_0101, g, o, w);
        checks++; if (o !== 32'h3000_0101) begin fails++; $display("FAIL rr_ptr1_tail: got %h need 30000101", o); end
        bus.reqInCntr = 10'h0;
        set_port(1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        bus.reqInCntr = 10'b10_0000_0001;
        set_port(9, 32'h2000_0900);
        serve_flit(0, 32'h2000_0A00, g, o, w);
        checks++; if (g !== 10'h001) begin fails++; $display("FAIL rr_first_gnt: got %h need 001", g); end
        checks++; if (o !== 32'h2000_0A00) begin fails++; $display("FAIL rr_first_out: got %h need 20000a00", o); end
        serve_flit(0, 32'h3000_0A01, g, o, w);
        set_port(0, 32'h2000_0A00);
        serve_flit(9, 32'h2000_0900, g, o, w);
        checks++; if (g !== 10'h200) begin fails++; $display("FAIL rr_second_gnt: got %h need 200", g); end
        checks++; if (o !== 32'h2000_0900) begin fails++; $display("FAIL rr_second_out: got %h need 20000900", o); end
        serve_flit(9, 32'h3000_0901, g, o, w);
        set_port(9, 32'h2000_0900);
        serve_flit(0, 32'h2000_0A00, g, o, w);
        checks++; if (g !== 10'h001) begin fails++; $display("FAIL rr_third_gnt: got %h need 001", g); end
        serve_flit(0, 32'h3000_0A01, g, o, w);
        checks++; if (o !== 32'h3000_0A01) begin fails++; $display("FAIL rr_third_tail: got %h need 30000a01", o); end
        bus.reqInCntr = 10'h0;
        set_port(0, 32'h0);
        set_port(9, 32'h0);
    endtask

    task automatic test_backpressure();
        logic [9:0]  g;
        logic [31:0] o;
        int          w;
        @(negedge clk);
        bus.reqInCntr = 10'h008;
        serve_flit(3, 32'h2100_0003, g, o, w);
        checks++; if (g !== 10'h008) begin fails++; $display("FAIL bp_head_gnt: got %h need 008", g); end
        checks++; if (o !== 32'h2100_0003) begin fails++; $display("FAIL bp_head_out: got %h need 21000003", o); end
        set_port(3, 32'h1100_0033);
        bus.full2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.full1 = (k % 2 == 1);
            #1;
            checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL bp_stall_gnt: got %h need 000", bus.gntInCntr); end
            @(posedge clk); #1;
            checks++; if (bus.PacketOut !== 32'h0) begin fails++; $display("FAIL bp_stall_out: got %h need 00000000", bus.PacketOut); end
            @(negedge clk);
        end
        bus.full2 = 1'b0;
        bus.full1 = 1'b1;
        serve_flit(3, 32'h1100_0033, g, o, w);
        checks++; if (w !== 0) begin fails++; $display("FAIL bp_resume_wait: got %0d need 0", w); end
        checks++; if (o !== 32'h1100_0033) begin fails++; $display("FAIL bp_body_out: got %h need 11000033", o); end
        bus.full1 = 1'b0;
        bus.reqInCntr = 10'h0;
        serve_flit(3, 32'h3100_0333, g, o, w);
        checks++; if (g !== 10'h008) begin fails++; $display("FAIL bp_tail_gnt: got %h need 008", g); end
        checks++; if (o !== 32'h3100_0333) begin fails++; $display("FAIL bp_tail_out: got %h need 31000333", o); end
        @(posedge clk); #1;
        checks++; if (bus.PacketOut !== 32'h0) begin fails++; $display("FAIL bp_no_dup: got %h need 00000000", bus.PacketOut); end
        checks++; if (bus.reqDnStr !== 1'b0) begin fails++; $display("FAIL bp_req_fall: got %b need 0", bus.reqDnStr); end
        @(negedge clk);
        set_port(3, 32'h0);
    endtask

    task automatic test_channel_grant();
        logic [9:0]  g;
        logic [31:0] o;
        int          w;
        @(negedge clk);
        bus.gntDnStr  = 1'b0;
        bus.reqInCntr = 10'h020;
        set_port(5, 32'h2000_0005);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.reqDnStr !== 1'b1) begin fails++; $display("FAIL cg_wait_req: got %b need 1", bus.reqDnStr); end
            checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL cg_wait_gnt: got %h need 000", bus.gntInCntr); end
        end
        bus.gntDnStr = 1'b1;
        #1;
        checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL cg_rise_gnt: got %h need 000", bus.gntInCntr); end
        @(negedge clk); #1;
        checks++; if (bus.gntInCntr !== 10'h020) begin fails++; $display("FAIL cg_first_gnt: got %h need 020", bus.gntInCntr); end
        @(posedge clk); #1;
        checks++; if (bus.PacketOut !== 32'h2000_0005) begin fails++; $display("FAIL cg_head_out: got %h need 20000005", bus.PacketOut); end
        @(negedge clk);
        bus.reqInCntr = 10'h0;
        serve_flit(5, 32'h3000_0055, g, o, w);
        checks++; if (o !== 32'h3000_0055) begin fails++; $display("FAIL cg_tail_out: got %h need 30000055", o); end
        set_port(5, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [9:0]  g;
        logic [31:0] o;
        int          w;
        @(negedge clk);
        bus.reqInCntr = 10'h084;
        set_port(2, 32'h2000_0002);
        serve_flit(7, 32'h2000_0007, g, o, w);
        checks++; if (g !== 10'h080) begin fails++; $display("FAIL ar_head_gnt: got %h need 080", g); end
        set_port(7, 32'h1000_0077);
        #1;
        checks++; if (bus.gntInCntr !== 10'h080) begin fails++; $display("FAIL ar_body_gnt: got %h need 080", bus.gntInCntr); end
        rst = 1'b1;
        #1;
        checks++; if (bus.gntInCntr !== 10'h0) begin fails++; $display("FAIL ar_clr_gnt: got %h need 000", bus.gntInCntr); end
        checks++; if (bus.reqDnStr !== 1'b0) begin fails++; $display("FAIL ar_clr_req: got %b need 0", bus.reqDnStr); end
        checks++; if (bus.PacketOut !== 32'h0) begin fails++; $display("FAIL ar_clr_out: got %h need 00000000", bus.PacketOut); end
        #1;
        rst = 1'b0;
        @(negedge clk);
        serve_flit(2, 32'h2000_0002, g, o, w);
        checks++; if (g !== 10'h004) begin fails++; $display("FAIL ar_rearb_gnt: got %h need 004", g); end
        checks++; if (o !== 32'h2000_0002) begin fails++; $display("FAIL ar_rearb_out: got %h need 20000002", o); end
        bus.reqInCntr = 10'h0;
        serve_flit(2, 32'h3000_0002, g, o, w);
        checks++; if (o !== 32'h3000_0002) begin fails++; $display("FAIL ar_tail_out: got %h need 30000002", o); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.gntDnStr  = 1'b0;
        bus.full1     = 1'b0;
        bus.full2     = 1'b0;
        bus.reqInCntr = 10'h0;
        for (int i = 0; i < 10; i++) set_port(i, 32'h0);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_channel_grant();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
